// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD alarm register, match edge detect and arm/ring/snooze FSM.
// Optional macro ALARM_BLINK_EN makes alarm_ring toggle once per second while ringing.
module alarm_ctrl #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic        alarm_clk,
  input  logic        alarm_rst_n,
  input  logic [15:0] alarm_time_in,
  input  logic        alarm_sec_tick,
  input  logic        alarm_set_en,
  input  logic [1:0]  alarm_set_sel,
  input  logic [3:0]  alarm_set_val,
  input  logic        alarm_set_wr,
  input  logic        alarm_arm,
  input  logic        alarm_snooze,
  input  logic        alarm_stop,
  output logic        alarm_ring,
  output logic [15:0] alarm_time_out,
  output logic [1:0]  alarm_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

  localparam logic [10:0] SNOOZE_ADD = 11'(SNOOZE_MIN);
  localparam logic [8:0]  RING_LIM   = 9'(RING_SEC);

  state_t      r_state;
  logic        r_ring;
  logic [15:0] r_time;
  logic [15:0] r_snooze;
  logic [7:0]  r_cnt;
  logic        r_match_a_q;
  logic        r_match_s_q;

  logic        w_match_a;
  logic        w_match_s;
  logic        w_trig_a;
  logic        w_trig_s;
  logic        w_wr_ok;
  logic [15:0] w_time_wr;
  logic        w_ring_last;
  logic [10:0] w_min_now;
  logic [10:0] w_min_sum;
  logic [10:0] w_min_wrap;
  logic [4:0]  w_hr;
  logic [5:0]  w_mn;
  logic [15:0] w_snz_bcd;

  assign w_match_a   = (alarm_time_in == r_time);
  assign w_match_s   = (alarm_time_in == r_snooze);
  assign w_trig_a    = w_match_a & ~r_match_a_q;
  assign w_trig_s    = w_match_s & ~r_match_s_q;
  assign w_ring_last = (({1'b0, r_cnt} + 9'd1) == RING_LIM);

  // Digit write validation; the 2x hour limit depends on the other hour digit.
  always_comb begin
    w_wr_ok   = 1'b0;
    w_time_wr = r_time;
    case (alarm_set_sel)
      2'd0: begin
        w_wr_ok         = (alarm_set_val <= 4'd9);
        w_time_wr[3:0]  = alarm_set_val;
      end
      2'd1: begin
        w_wr_ok         = (alarm_set_val <= 4'd5);
        w_time_wr[7:4]  = alarm_set_val;
      end
      2'd2: begin
        w_wr_ok         = (alarm_set_val <= 4'd9) &&
                          !((r_time[15:12] == 4'd2) && (alarm_set_val > 4'd3));
        w_time_wr[11:8] = alarm_set_val;
      end
      default: begin
        w_wr_ok          = (alarm_set_val <= 4'd2) &&
                           !((alarm_set_val == 4'd2) && (r_time[11:8] > 4'd3));
        w_time_wr[15:12] = alarm_set_val;
      end
    endcase
    w_wr_ok = w_wr_ok && alarm_set_en && alarm_set_wr;
  end

  // Snooze target: current time in minutes plus SNOOZE_MIN, wrapped at 24:00.
  always_comb begin
    w_min_now  = 11'(alarm_time_in[15:12]) * 11'd600 + 11'(alarm_time_in[11:8]) * 11'd60 +
                 11'(alarm_time_in[7:4]) * 11'd10 + 11'(alarm_time_in[3:0]);
    w_min_sum  = w_min_now + SNOOZE_ADD;
    w_min_wrap = (w_min_sum >= 11'd1440) ? (w_min_sum - 11'd1440) : w_min_sum;
    w_hr       = 5'(w_min_wrap / 11'd60);
    w_mn       = 6'(w_min_wrap % 11'd60);
    w_snz_bcd  = {4'(w_hr / 5'd10), 4'(w_hr % 5'd10), 4'(w_mn / 6'd10), 4'(w_mn % 6'd10)};
  end

  always_ff @(posedge alarm_clk or negedge alarm_rst_n) begin
    if (!alarm_rst_n) begin
      r_state     <= ST_IDLE;
      r_ring      <= 1'b0;
      r_time      <= 16'h0000;
      r_snooze    <= 16'h0000;
      r_cnt       <= 8'd0;
      r_match_a_q <= 1'b0;
      r_match_s_q <= 1'b0;
    end else begin
      r_match_a_q <= w_match_a;
      r_match_s_q <= w_match_s;
      if (w_wr_ok)
        r_time <= w_time_wr;

      if (r_state == ST_IDLE) begin
        if (alarm_arm && !alarm_set_en)
          r_state <= ST_ARMED;
      end else if (alarm_set_en || !alarm_arm) begin
        r_state <= ST_IDLE;
        r_ring  <= 1'b0;
      end else begin
        case (r_state)
          ST_ARMED: begin
            if (w_trig_a) begin
              r_state <= ST_RINGING;
              r_ring  <= 1'b1;
              r_cnt   <= 8'd0;
            end
          end
          ST_RINGING: begin
            if (alarm_stop) begin
              r_state <= ST_ARMED;
              r_ring  <= 1'b0;
            end else if (alarm_snooze) begin
              r_state  <= ST_SNOOZE;
              r_ring   <= 1'b0;
              r_snooze <= w_snz_bcd;
            end else if (alarm_sec_tick) begin
              if (w_ring_last) begin
                r_state <= ST_ARMED;
                r_ring  <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 8'd1;
`ifdef ALARM_BLINK_EN
                r_ring <= ~r_ring;
`endif
              end
            end
          end
          default: begin
            if (alarm_stop) begin
              r_state <= ST_ARMED;
            end else if (w_trig_s) begin
              r_state <= ST_RINGING;
              r_ring  <= 1'b1;
              r_cnt   <= 8'd0;
            end
          end
        endcase
      end
    end
  end

  assign alarm_ring     = r_ring;
  assign alarm_time_out = r_time;
  assign alarm_state    = r_state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: expectations queued with stimulus, popped after each edge.
module tb_alarm_ctrl;
  localparam int SNZ  = 5;
  localparam int RSEC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] time_in = 16'h0000;
  logic        sec_tick = 1'b0;
  logic        set_en = 1'b0;
  logic [1:0]  set_sel = 2'd0;
  logic [3:0]  set_val = 4'd0;
  logic        set_wr = 1'b0;
  logic        arm = 1'b0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  logic        ring;
  logic [15:0] time_out;
  logic [1:0]  state;

  always #5 clk = ~clk;

  alarm_ctrl #(.SNOOZE_MIN(SNZ), .RING_SEC(RSEC)) dut (
    .alarm_clk(clk), .alarm_rst_n(rst_n), .alarm_time_in(time_in),
    .alarm_sec_tick(sec_tick), .alarm_set_en(set_en), .alarm_set_sel(set_sel),
    .alarm_set_val(set_val), .alarm_set_wr(set_wr), .alarm_arm(arm),
    .alarm_snooze(snooze), .alarm_stop(stop), .alarm_ring(ring),
    .alarm_time_out(time_out), .alarm_state(state)
  );

  typedef struct {
    string tag;
    int    kind;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  function automatic logic [15:0] model_snooze(input logic [15:0] t, input int n);
    int h, m;
    h = int'(t[15:12]) * 10 + int'(t[11:8]);
    m = int'(t[7:4]) * 10 + int'(t[3:0]);
    repeat (n) begin
      m++;
      if (m == 60) begin m = 0; h++; end
      if (h == 24) h = 0;
    end
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic exp3(input string tag, input int st, input int rg, input logic [15:0] tm);
    exp_t e;
    e.tag = {tag, ".state"}; e.kind = 0; e.val = 32'(st); sb_q.push_back(e);
    e.tag = {tag, ".ring"};  e.kind = 1; e.val = 32'(rg); sb_q.push_back(e);
    e.tag = {tag, ".time"};  e.kind = 2; e.val = 32'(tm); sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       act = 32'(state);
        1:       act = 32'(ring);
        default: act = 32'(time_out);
      endcase
      check_val(e.tag, act, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    set_wr = 1'b0; snooze = 1'b0; stop = 1'b0; sec_tick = 1'b0;
    drain();
  endtask

  task automatic wr(input int sel, input int val);
    set_sel = 2'(sel); set_val = 4'(val); set_wr = 1'b1;
  endtask

  logic [15:0] tgt;

  initial begin
    #12;
    exp3("reset", 0, 0, 16'h0000); drain();
    rst_n = 1'b1;

    set_en = 1'b1;
    wr(0, 0); exp3("wr_m0", 0, 0, 16'h0000); step();
    wr(1, 3); exp3("wr_m1", 0, 0, 16'h0030); step();
    wr(2, 7); exp3("wr_h0", 0, 0, 16'h0730); step();
    wr(3, 0); exp3("wr_h1", 0, 0, 16'h0730); step();
    wr(1, 6); exp3("rej_m1_6", 0, 0, 16'h0730); step();
    wr(3, 2); exp3("rej_h1_2", 0, 0, 16'h0730); step();
    set_en = 1'b0;

    time_in = 16'h0729; arm = 1'b1; exp3("arm", 1, 0, 16'h0730); step();
    time_in = 16'h0730; exp3("match", 2, 1, 16'h0730); step();
    sec_tick = 1'b1; exp3("tick1", 2, 1, 16'h0730); step();
    exp3("notick", 2, 1, 16'h0730); step();
    sec_tick = 1'b1; exp3("tick2", 2, 1, 16'h0730); step();
    sec_tick = 1'b1; exp3("tick3_auto", 1, 0, 16'h0730); step();
    exp3("no_retrig", 1, 0, 16'h0730); step();
    arm = 1'b0; exp3("disarm", 0, 0, 16'h0730); step();
    arm = 1'b1; exp3("arm_at_match", 1, 0, 16'h0730); step();
    exp3("arm_at_match2", 1, 0, 16'h0730); step();
    time_in = 16'h0731; exp3("t0731", 1, 0, 16'h0730); step();
    time_in = 16'h0730; exp3("rering", 2, 1, 16'h0730); step();
    stop = 1'b1; snooze = 1'b1; exp3("stop_gt_snz", 1, 0, 16'h0730); step();
    time_in = 16'h0731; exp3("t0731b", 1, 0, 16'h0730); step();
    time_in = 16'h0730; exp3("rering2", 2, 1, 16'h0730); step();
    arm = 1'b0; snooze = 1'b1; exp3("disarm_gt_snz", 0, 0, 16'h0730); step();

    set_en = 1'b1;
    wr(2, 3); exp3("wr_h0_3", 0, 0, 16'h0330); step();
    wr(3, 2); exp3("wr_h1_2", 0, 0, 16'h2330); step();
    wr(2, 5); exp3("rej_h0_5", 0, 0, 16'h2330); step();
    wr(1, 5); exp3("wr_m1_5", 0, 0, 16'h2350); step();
    wr(0, 8); exp3("wr_m0_8", 0, 0, 16'h2358); step();
    wr(0, 10); exp3("rej_m0_10", 0, 0, 16'h2358); step();
    set_en = 1'b0; arm = 1'b1;
    time_in = 16'h2357; exp3("arm2", 1, 0, 16'h2358); step();
    time_in = 16'h2358; exp3("ring2358", 2, 1, 16'h2358); step();
    tgt = model_snooze(16'h2358, SNZ);
    snooze = 1'b1; exp3("snooze", 3, 0, 16'h2358); step();
    time_in = 16'h0002; exp3("snz_wait", 3, 0, 16'h2358); step();
    time_in = tgt; exp3("snz_wrap_ring", 2, 1, 16'h2358); step();
    snooze = 1'b1; exp3("snooze2", 3, 0, 16'h2358); step();
    tgt = model_snooze(tgt, SNZ);
    time_in = 16'h1200; exp3("snz2_wait", 3, 0, 16'h2358); step();
    time_in = tgt; exp3("snz2_ring", 2, 1, 16'h2358); step();
    snooze = 1'b1; exp3("snooze3", 3, 0, 16'h2358); step();
    stop = 1'b1; exp3("snz_stop", 1, 0, 16'h2358); step();
    set_en = 1'b1; exp3("set_en_idle", 0, 0, 16'h2358); step();
    set_en = 1'b0; exp3("rearm", 1, 0, 16'h2358); step();
    time_in = 16'h2357; exp3("t2357", 1, 0, 16'h2358); step();
    time_in = 16'h2358; exp3("ring_pre_rst", 2, 1, 16'h2358); step();

    #2;
    rst_n = 1'b0;
    #1;
    exp3("async_rst", 0, 0, 16'h0000); drain();
    #3;
    rst_n = 1'b1;
    exp3("post_rst", 1, 0, 16'h0000); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
